fir_approx_param: RTL
=====================

Name: fir_approx_param

Overview:
- Parametrised successor to the fixed 5-tap shift-coefficient FIR: unsigned direct-form FIR with TAPS taps and WIDTH-bit samples.
- Each tap's coefficient is a power-of-two right shift.
- Partial sums are accumulated through an LSB-approximate adder, with a runtime exact/approximate mode select.
- Adds a valid handshake, a registered output, and fill tracking.
- Sits in the FIR datapath between sample source and downstream consumer.

Parameters:
- WIDTH, 16: sample, partial-sum and output width in bits.
- TAPS, 5: number of taps; must be ≥ 2.
- APPROX_K, 6: number of low carry positions made carry-free in approximate mode; 0 ≤ APPROX_K < WIDTH.
- SHIFTS, {4'd1,4'd2,4'd3,4'd4,4'd5}: packed TAPS×4 bits. Tap i shift is SHIFTS[4i+3:4i]. Tap 0 is the newest sample; default shifts are 5,4,3,2,1.

Ports:
- clk  in  1: single clock; all state updates on rising edge.
- rst  in  1: synchronous, active-low reset (rst==0 resets on the clk edge).
- in_valid  in  1: in_data is a new sample this cycle.
- in_data  in  WIDTH: unsigned sample.
- approx_en  in  1: 1 = approximate adder, 0 = exact. Sampled with the accepted sample.
- out_valid  out  1: one-cycle pulse; out_data holds a new result.
- out_data  out  WIDTH: filter result, modulo 2^WIDTH.
- out_primed  out  1: the result of this out_valid used a fully filled window.

Behaviour:
- Reset (rst==0 at the edge):
  - delay line (TAPS-1 words) cleared to 0
  - fill_cnt = 0
  - out_valid = 0, out_data = 0, out_primed = 0
  - Reset overrides in_valid the same cycle; a mid-stream reset discards all history.
- Sample acceptance: every cycle with in_valid==1 accepts a sample. There is no backpressure; the consumer must take each out_valid pulse.
- Tap terms: t0 = in_data >> SH0 and ti = dline[i-1] >> SHi, using the delay line before the update. Shifts are logical (zero fill); a shift ≥ WIDTH gives 0.
- Accumulation order is fixed, because approximation error depends on it:
  - acc0 = t0
  - acc_i = ADD(acc_{i-1}, t_i) for i = 1..TAPS-1
  - result = acc_{TAPS-1}
- Register updates on an accepted sample, at that edge:
  - out_data <= result
  - out_valid <= 1
  - out_primed <= (fill_cnt ≥ TAPS-1)
  - delay line shifts: dline[0] <= in_data, dline[i] <= dline[i-1]
  - fill_cnt <= min(fill_cnt+1, TAPS)
- Latency: 1 cycle from accepted sample to out_valid.
- No accepted sample: out_valid <= 0; out_data, out_primed, delay line and fill_cnt hold.
- ADD(a,b), WIDTH bits, with pi = ai^bi, gi = ai&bi, ci = carry into bit i:
  - c0 = 0; sum_i = pi ^ ci; the carry out of the MSB is discarded (wrap-around).
  - Exact mode: ci = g(i-1) | p(i-1)&c(i-1) for i ≥ 1.
  - Approximate mode: ci = g(i-1) for 1 ≤ i ≤ APPROX_K; ci follows the exact rule for i > APPROX_K.
  - APPROX_K = 0 makes both modes identical.
- Mode switching: approx_en may change on any cycle. It applies to all TAPS-1 adders of the sample accepted that cycle; there is no glitch or flush.
- The adder chain is purely combinational between the input/delay line and the out_data register.

Decomposition:
- Package fir_approx_pkg:
  - SHIFT_W = 4
  - default SHIFTS constant
  - shift-extract function get_shift(SHIFTS, i)
- Sub-module lsb_approx_adder:
  - parameters WIDTH, APPROX_K
  - ports a, b, approx_en, sum
  - purely combinational; one instance per tap 1..TAPS-1, generated.

Test Plan:
- Defaults, exact mode; one sample 0x8000, then zeros, all with in_valid=1 → out_data 0x0400, 0x0800, 0x1000, 0x2000, 0x4000, 0x0000. out_primed = 0 for the first four outputs, 1 from the fifth onward.
- Defaults; in_data = 0xFFFF continuously, exact vs approx runs → exact outputs 0x07FF, 0x17FE, then the rest per the formula with 16-bit wrap. Approx outputs bit-compared against a reference model implementing ADD exactly as specified.
- lsb_approx_adder unit test, WIDTH=16, K=6: a=0x003F, b=0x0001 → approx sum 0x003C, exact sum 0x0040. With K=0 → 0x0040 in both modes.
- Gapped in_valid (1,0,0,1,1, random gaps) → out_valid pulses exactly one cycle after each accepted sample. out_data and state hold through gaps, and results match the gap-free sequence.
- Assert rst=0 for one cycle after three samples → next cycle out_valid=0, out_data=0. The next accepted sample 0x8000 yields 0x0400 with out_primed=0, confirming no stale history.
- Toggle approx_en every sample with random data, and run with TAPS=8, WIDTH=24, APPROX_K=10 → every output matches the model using the approx_en value sampled with that input.

Source files
------------

// File: rtl/fir_approx_pkg.sv
// Shared constants and helpers for the shift-coefficient approximate FIR.
package fir_approx_pkg;

  localparam int SHIFT_W  = 4;
  // Upper bound on TAPS supported by the shift-extract helper.
  localparam int MAX_TAPS = 32;
  localparam int EXT_W    = SHIFT_W * MAX_TAPS;

  // Tap 0 (newest sample) lives in the low nibble: shifts 5,4,3,2,1.
  localparam logic [SHIFT_W*5-1:0] DEFAULT_SHIFTS = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};

  // Pull tap i's shift amount out of a (zero-extended) packed shift vector.
  function automatic int get_shift(input logic [EXT_W-1:0] shifts, input int i);
    return int'(shifts[SHIFT_W*i +: SHIFT_W]);
  endfunction

endpackage

// File: rtl/fir_approx_param_adder.sv
// WIDTH-bit adder whose low APPROX_K carries can be cut to generate-only.
module lsb_approx_adder #(
  parameter int WIDTH    = 16,
  parameter int APPROX_K = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             approx_en,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] p, g, c;

  // Ripple carry; in approximate mode carries into bits 1..APPROX_K ignore propagate.
  always_comb begin
    p = a ^ b;
    g = a & b;
    c = '0;
    for (int i = 1; i < WIDTH; i++) begin
      if (approx_en && (i <= APPROX_K)) c[i] = g[i-1];
      else                              c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    sum = p ^ c;
  end

endmodule

// File: rtl/fir_approx_param.sv
// Unsigned direct-form FIR with power-of-two shift taps, LSB-approximate
// accumulation chain, registered output and window-fill tracking.
module fir_approx_param
  import fir_approx_pkg::*;
#(
  parameter int                       WIDTH    = 16,
  parameter int                       TAPS     = 5,
  parameter int                       APPROX_K = 6,
  parameter logic [SHIFT_W*TAPS-1:0]  SHIFTS   = DEFAULT_SHIFTS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             approx_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_primed
);

  localparam int                 CNT_W      = $clog2(TAPS + 1);
  localparam logic [EXT_W-1:0]   SHIFTS_EXT = EXT_W'(SHIFTS);
  localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0]   PRIME_CNT  = CNT_W'(TAPS - 1);

  logic [TAPS-2:0][WIDTH-1:0] dline;
  logic [TAPS-1:0][WIDTH-1:0] term;
  logic [WIDTH-1:0]           acc [TAPS];
  logic [CNT_W-1:0]           fill_cnt;

  // Per-tap shift term and one chained adder per tap after the first;
  // the chain order is fixed since approximation error depends on it.
  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    localparam int SH = get_shift(SHIFTS_EXT, i);
    if (i == 0) begin : g_head
      assign term[i] = in_data >> SH;
      assign acc[0]  = term[0];
    end else begin : g_add
      assign term[i] = dline[i-1] >> SH;
      lsb_approx_adder #(.WIDTH(WIDTH), .APPROX_K(APPROX_K)) u_add (
        .a         (acc[i-1]),
        .b         (term[i]),
        .approx_en (approx_en),
        .sum       (acc[i])
      );
    end
  end

  // Accept a sample: register the result, advance the delay line and fill count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dline      <= '0;
      fill_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_primed <= 1'b0;
    end else if (in_valid) begin
      out_valid  <= 1'b1;
      out_data   <= acc[TAPS-1];
      out_primed <= (fill_cnt >= PRIME_CNT);
      dline[0]   <= in_data;
      for (int i = 1; i < TAPS - 1; i++) dline[i] <= dline[i-1];
      if (fill_cnt < FULL_CNT) fill_cnt <= fill_cnt + CNT_W'(1);
    end else begin
      out_valid  <= 1'b0;
    end
  end

endmodule
